// File: rtl/pc_lut_encoder.sv
// pc_lut_encoder: builds the branch-target table read by PC_LUT.
// Each request carries an absolute target. The block returns the 4-bit table index for that
// target and allocates a new entry when the target is not already stored.
// Build option: PC_LUT_ENC_DEDUP_EN enables searching the stored targets before allocating.
// Without it, every request allocates and duplicates are stored.
module pc_lut_encoder #(
  parameter int unsigned D = 10,
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [D-1:0] in_target,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_idx,
  output logic         out_new,
  output logic         out_err,
  output logic         lut_we,
  output logic [3:0]   lut_waddr,
  output logic [D-1:0] lut_wdata,
  output logic [4:0]   count
);

  localparam logic [4:0] Full = 5'(N);

  typedef enum logic [1:0] {StIdle, StScan, StAlloc, StResp} state_e;

  state_e       state_q, state_d;
  logic [D-1:0] tgt_q, tgt_d;
  logic [4:0]   count_q, count_d;
  logic         out_valid_q, out_valid_d;
  logic [3:0]   out_idx_q, out_idx_d;
  logic         out_new_q, out_new_d;
  logic         out_err_q, out_err_d;
  logic         lut_we_q, lut_we_d;
  logic [3:0]   lut_waddr_q, lut_waddr_d;
  logic [D-1:0] lut_wdata_q, lut_wdata_d;

`ifdef PC_LUT_ENC_DEDUP_EN
  logic [4:0]   ptr_q, ptr_d;
  // Only the search reads the shadow, so it exists only when dedup is built in.
  logic [D-1:0] shadow_q [N];
  logic         shadow_we;
`endif

  // in_ready is the only unregistered output; a flush in progress masks it.
  assign in_ready  = (state_q == StIdle) && !reset && !clear;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_new   = out_new_q;
  assign out_err   = out_err_q;
  assign lut_we    = lut_we_q;
  assign lut_waddr = lut_waddr_q;
  assign lut_wdata = lut_wdata_q;
  assign count     = count_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_new_d   = out_new_q;
    out_err_d   = out_err_q;
    lut_we_d    = 1'b0;
    lut_waddr_d = lut_waddr_q;
    lut_wdata_d = lut_wdata_q;
`ifdef PC_LUT_ENC_DEDUP_EN
    ptr_d       = ptr_q;
    shadow_we   = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          tgt_d = in_target;
`ifdef PC_LUT_ENC_DEDUP_EN
          ptr_d   = '0;
          state_d = StScan;
`else
          if (count_q == Full) begin
            state_d     = StResp;
            out_valid_d = 1'b1;
            out_idx_d   = '0;
            out_new_d   = 1'b0;
            out_err_d   = 1'b1;
          end else begin
            state_d     = StAlloc;
            lut_we_d    = 1'b1;
            lut_waddr_d = count_q[3:0];
            lut_wdata_d = in_target;
          end
`endif
        end
      end

`ifdef PC_LUT_ENC_DEDUP_EN
      StScan: begin
        if (ptr_q < count_q) begin
          if (shadow_q[ptr_q[3:0]] == tgt_q) begin
            state_d     = StResp;
            out_valid_d = 1'b1;
            out_idx_d   = ptr_q[3:0];
            out_new_d   = 1'b0;
            out_err_d   = 1'b0;
          end else begin
            ptr_d = ptr_q + 5'd1;
          end
        end else if (count_q < Full) begin
          // Write strobe is registered so it is high exactly during ALLOC.
          state_d     = StAlloc;
          lut_we_d    = 1'b1;
          lut_waddr_d = count_q[3:0];
          lut_wdata_d = tgt_q;
        end else begin
          state_d     = StResp;
          out_valid_d = 1'b1;
          out_idx_d   = '0;
          out_new_d   = 1'b0;
          out_err_d   = 1'b1;
        end
      end
`endif

      StAlloc: begin
`ifdef PC_LUT_ENC_DEDUP_EN
        shadow_we   = 1'b1;
`endif
        count_d     = count_q + 5'd1;
        state_d     = StResp;
        out_valid_d = 1'b1;
        out_idx_d   = count_q[3:0];
        out_new_d   = 1'b1;
        out_err_d   = 1'b0;
      end

      StResp: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State register; reset and clear both flush everything and drop any in-flight request.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q     <= StIdle;
      tgt_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_new_q   <= 1'b0;
      out_err_q   <= 1'b0;
      lut_we_q    <= 1'b0;
      lut_waddr_q <= '0;
      lut_wdata_q <= '0;
`ifdef PC_LUT_ENC_DEDUP_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_new_q   <= out_new_d;
      out_err_q   <= out_err_d;
      lut_we_q    <= lut_we_d;
      lut_waddr_q <= lut_waddr_d;
      lut_wdata_q <= lut_wdata_d;
`ifdef PC_LUT_ENC_DEDUP_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

`ifdef PC_LUT_ENC_DEDUP_EN
  // Shadow copy of the entries written to PC_LUT, written in the same cycle as the table.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shadow_q <= '{default: '0};
    end else if (shadow_we) begin
      shadow_q[count_q[3:0]] <= tgt_q;
    end
  end
`endif

endmodule

// File: tb/tb_pc_lut_encoder.sv
// Self-checking bench for pc_lut_encoder; follows PC_LUT_ENC_DEDUP_EN like the design.
module tb_pc_lut_encoder;
  localparam int D = 10;
  localparam int N = 16;

`ifdef PC_LUT_ENC_DEDUP_EN
  localparam bit Dedup = 1'b1;
`else
  localparam bit Dedup = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, clear, in_valid, in_ready, out_valid, out_ready;
  logic         out_new, out_err, lut_we;
  logic [D-1:0] in_target, lut_wdata;
  logic [3:0]   out_idx, lut_waddr;
  logic [4:0]   count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_lut_encoder #(.D(D), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_target (in_target),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_new   (out_new),
    .out_err   (out_err),
    .lut_we    (lut_we),
    .lut_waddr (lut_waddr),
    .lut_wdata (lut_wdata),
    .count     (count)
  );

  // Expected outcome of one request.
  typedef struct {
    logic [D-1:0] tgt;
    int           idx;
    int           nw;
    int           err;
    int           vcyc;   // first cycle with out_valid
    int           we;     // number of write-strobe cycles
    int           wecyc;  // cycle of the write strobe
    int           cnt;    // count after the response
    bit           clr;    // clear the table before this vector
  } exp_t;

  // Reference model: ordered list of targets held in the table.
  logic [D-1:0] tbl[$];
  // Contents of PC_LUT as seen through the write port.
  logic [D-1:0] lut_mem [16];

  always @(negedge clk) if (lut_we === 1'b1) lut_mem[lut_waddr] <= lut_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t predict(input logic [D-1:0] t);
    exp_t e;
    int   hit;
    e.tgt = t; e.clr = 1'b0; e.idx = 0; e.nw = 0; e.err = 0; e.we = 0; e.wecyc = 0;
    hit = -1;
    if (Dedup) begin
      foreach (tbl[j]) if (hit < 0 && tbl[j] == t) hit = j;
    end
    if (hit >= 0) begin
      e.idx = hit; e.vcyc = hit + 2;
    end else if (tbl.size() < N) begin
      e.idx = tbl.size(); e.nw = 1; e.we = 1;
      e.wecyc = Dedup ? tbl.size() + 2 : 1;
      e.vcyc  = Dedup ? tbl.size() + 3 : 2;
      tbl.push_back(t);
    end else begin
      e.err = 1;
      e.vcyc = Dedup ? N + 2 : 1;
    end
    e.cnt = tbl.size();
    return e;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tbl.delete();
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    tbl.delete();
  endtask

  // Issue one request, measure latency from the acceptance edge and compare with e.
  task automatic run_req(input string nm, input exp_t e, input int hold);
    int vcyc, wecnt, wecyc, idx, nw, err;
    logic [3:0]   waddr;
    logic [D-1:0] wdata;
    vcyc = -1; wecnt = 0; wecyc = -1; idx = 0; nw = 0; err = 0; waddr = '0; wdata = '0;
    out_ready = (hold == 0);
    @(negedge clk);
    chk({nm, "_in_ready_idle"}, in_ready, 1);
    in_valid  = 1'b1;
    in_target = e.tgt;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_target = D'($urandom);
    for (int c = 1; c <= 40 && vcyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) chk({nm, "_in_ready_busy"}, in_ready, 0);
      if (lut_we === 1'b1) begin
        wecnt++;
        if (wecyc < 0) wecyc = c;
        waddr = lut_waddr;
        wdata = lut_wdata;
      end
      if (out_valid === 1'b1) begin
        vcyc = c; idx = int'(out_idx); nw = int'(out_new); err = int'(out_err);
      end
    end
    if (vcyc < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no out_valid within 40 cycles, expected in cycle %0d", nm, e.vcyc);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      return;
    end
    chk({nm, "_vcyc"}, vcyc, e.vcyc);
    chk({nm, "_idx"}, idx, e.idx);
    chk({nm, "_new"}, nw, e.nw);
    chk({nm, "_err"}, err, e.err);
    chk({nm, "_we_cycles"}, wecnt, e.we);
    if (e.we != 0) begin
      chk({nm, "_we_cyc"}, wecyc, e.wecyc);
      chk({nm, "_waddr"}, waddr, e.idx);
      chk({nm, "_wdata"}, wdata, e.tgt);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, "_bp_valid"}, out_valid, 1);
      chk({nm, "_bp_idx"}, out_idx, e.idx);
      chk({nm, "_bp_new"}, out_new, e.nw);
      chk({nm, "_bp_in_ready"}, in_ready, 0);
      chk({nm, "_bp_we"}, lut_we, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_back_idle"}, in_ready, 1);
    chk({nm, "_valid_drop"}, out_valid, 0);
    chk({nm, "_count"}, count, e.cnt);
  endtask

  // Start a miss, hold the response back, and flush with clear in cycle cc.
  task automatic clear_mid(input logic [D-1:0] t, input int cc);
    int we_seen, v_seen;
    we_seen = 0; v_seen = 0;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_target = t;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (cc - 1) @(posedge clk);
    #1 clear = 1'b1;
    @(negedge clk);
    chk("clr_in_ready_masked", in_ready, 0);
    @(posedge clk);
    #1 clear = 1'b0;
    tbl.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (lut_we === 1'b1) we_seen++;
      if (out_valid === 1'b1) v_seen++;
    end
    chk("clr_no_write", we_seen, 0);
    chk("clr_no_resp", v_seen, 0);
    chk("clr_count", count, 0);
    chk("clr_idle", in_ready, 1);
    out_ready = 1'b1;
  endtask

  exp_t vec [6];
  exp_t e;

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_target = '0;
    foreach (lut_mem[k]) lut_mem[k] = '0;

`ifdef PC_LUT_ENC_DEDUP_EN
    vec[0] = '{10'h004, 0, 1, 0, 3, 1, 2, 1, 1'b0};
    vec[1] = '{10'h3FB, 1, 1, 0, 4, 1, 3, 2, 1'b0};
    vec[2] = '{10'h014, 2, 1, 0, 5, 1, 4, 3, 1'b0};
    vec[3] = '{10'h3FB, 1, 0, 0, 3, 0, 0, 3, 1'b0};
    vec[4] = '{10'h014, 0, 1, 0, 3, 1, 2, 1, 1'b1};
    vec[5] = '{10'h014, 0, 0, 0, 2, 0, 0, 1, 1'b0};
`else
    vec[0] = '{10'h004, 0, 1, 0, 2, 1, 1, 1, 1'b0};
    vec[1] = '{10'h3FB, 1, 1, 0, 2, 1, 1, 2, 1'b0};
    vec[2] = '{10'h014, 2, 1, 0, 2, 1, 1, 3, 1'b0};
    vec[3] = '{10'h3FB, 3, 1, 0, 2, 1, 1, 4, 1'b0};
    vec[4] = '{10'h014, 0, 1, 0, 2, 1, 1, 1, 1'b1};
    vec[5] = '{10'h014, 1, 1, 0, 2, 1, 1, 2, 1'b0};
`endif

    // Reset state.
    @(negedge clk);
    chk("rst_in_ready_low", in_ready, 0);
    do_reset();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_new", out_new, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_lut_we", lut_we, 0);
    chk("rst_lut_waddr", lut_waddr, 0);
    chk("rst_lut_wdata", lut_wdata, 0);
    chk("rst_count", count, 0);

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      if (vec[i].clr) do_clear();
      e = predict(vec[i].tgt);
      run_req($sformatf("vec%0d", i), vec[i], 0);
    end

    // Backpressure: response held for 5 cycles.
    do_reset();
    e = predict(10'h2AA);
    run_req("bp", e, 5);

    // Fill the table, then a miss with the table full.
    do_reset();
    for (int t = 0; t < N; t++) begin
      e = predict(D'(t));
      run_req($sformatf("fill%0d", t), e, 0);
    end
    e = predict(10'h3FF);
    run_req("full", e, 0);

    // Clear during an outstanding request, then the table starts again from index 0.
    do_reset();
    for (int t = 0; t < 8; t++) begin
      e = predict(D'(10'h100 + t));
      run_req($sformatf("pre%0d", t), e, 0);
    end
    clear_mid(10'h2F0, Dedup ? 4 : 2);
    e = predict(10'h004);
    run_req("post_clr", e, 0);

    // Random requests against the model; small pool so hits and full-table misses occur.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      logic [D-1:0] t;
      if (n % 20 == 19) do_clear();
      t = ($urandom_range(0, 3) == 0) ? D'($urandom) : D'($urandom_range(0, 23));
      e = predict(t);
      run_req("rand", e, $urandom_range(0, 2));
    end
    foreach (tbl[j]) chk($sformatf("lut_entry%0d", j), lut_mem[j], tbl[j]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "watchdog");
  end

endmodule
